// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: MEM->WB bus layout, CP0 map, exception codes.
package wb_pkg;
  localparam int MEM_WB_W  = 118;
  localparam int EXC_BUS_W = 33;

  // LSB offsets of the MEM->WB bus fields
  localparam int BUS_PC_LSB         = 0;
  localparam int BUS_ERET           = 32;
  localparam int BUS_SYSCALL        = 33;
  localparam int BUS_CP0_ADDR_LSB   = 34;
  localparam int BUS_MFC0           = 42;
  localparam int BUS_MTC0           = 43;
  localparam int BUS_MFLO           = 44;
  localparam int BUS_MFHI           = 45;
  localparam int BUS_LO_WRITE       = 46;
  localparam int BUS_HI_WRITE       = 47;
  localparam int BUS_LO_RESULT_LSB  = 48;
  localparam int BUS_MEM_RESULT_LSB = 80;
  localparam int BUS_RF_WDEST_LSB   = 112;
  localparam int BUS_RF_WEN         = 117;

  localparam logic [7:0] CP0_STATUS_ADDR = 8'h60;
  localparam logic [7:0] CP0_CAUSE_ADDR  = 8'h68;
  localparam logic [7:0] CP0_EPC_ADDR    = 8'h70;

  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam int         STATUS_EXL  = 1;
endpackage

// File: rtl/wb_cp0_regs.sv
// Minimal CP0 (STATUS, CAUSE, EPC): syscall > eret > mtc0 on the write side.
// Latency: writes land on the next clk edge, reads are combinational.
// Backpressure: none, every request is accepted.
module cp0_regs
  import wb_pkg::*;
#(
  parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        syscall,
  input  logic        eret,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status <= '0;
      cause  <= '0;
      epc    <= '0;
    end else if (syscall) begin
      epc               <= pc;
      cause[6:2]        <= EXCCODE_SYS;
      status[STATUS_EXL] <= 1'b1;
    end else if (eret) begin
      status[STATUS_EXL] <= 1'b0;
    end else if (wen) begin
      // CAUSE is deliberately absent: software cannot write it
      if (addr == CP0_STATUS_ADDR)
        status <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
      else if (addr == CP0_EPC_ADDR)
        epc <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_STATUS_ADDR: rdata = status;
      CP0_CAUSE_ADDR:  rdata = cause;
      CP0_EPC_ADDR:    rdata = epc;
      default:         rdata = '0;
    endcase
  end

endmodule

// File: rtl/wb.sv
// Write-back stage: register-file write, HI/LO, CP0 and syscall/eret redirect.
// Latency: single cycle, WB_over follows WB_valid.
// Backpressure: none, the stage never stalls.
module wb
  import wb_pkg::*;
#(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000,
  parameter logic [31:0] STATUS_WMASK   = 32'h0000_FF03
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 WB_valid,
  input  logic [MEM_WB_W-1:0]  MEM_WB_bus_r,
  output logic                 rf_wen,
  output logic [4:0]           rf_wdest,
  output logic [31:0]          rf_wdata,
  output logic                 WB_over,
  output logic [4:0]           WB_wdest,
  output logic                 WB_RegWrite,
  output logic [31:0]          WB_data,
  output logic [EXC_BUS_W-1:0] exc_bus,
  output logic                 cancel,
  output logic [31:0]          WB_pc,
  output logic [31:0]          HI_data,
  output logic [31:0]          LO_data,
  output logic [31:0]          cp0r_status,
  output logic [31:0]          cp0r_cause,
  output logic [31:0]          cp0r_epc
);

  logic        bus_rf_wen, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, syscall, eret;
  logic [31:0] mem_result, lo_result, pc, cp0_rdata, hi_q, lo_q;
  logic [7:0]  cp0_addr;
  logic        exc_valid;
  logic [31:0] exc_pc;

  assign bus_rf_wen = MEM_WB_bus_r[BUS_RF_WEN];
  assign rf_wdest   = MEM_WB_bus_r[BUS_RF_WDEST_LSB +: 5];
  assign mem_result = MEM_WB_bus_r[BUS_MEM_RESULT_LSB +: 32];
  assign lo_result  = MEM_WB_bus_r[BUS_LO_RESULT_LSB +: 32];
  assign hi_write   = MEM_WB_bus_r[BUS_HI_WRITE];
  assign lo_write   = MEM_WB_bus_r[BUS_LO_WRITE];
  assign mfhi       = MEM_WB_bus_r[BUS_MFHI];
  assign mflo       = MEM_WB_bus_r[BUS_MFLO];
  assign mtc0       = MEM_WB_bus_r[BUS_MTC0];
  assign mfc0       = MEM_WB_bus_r[BUS_MFC0];
  assign cp0_addr   = MEM_WB_bus_r[BUS_CP0_ADDR_LSB +: 8];
  assign syscall    = MEM_WB_bus_r[BUS_SYSCALL];
  assign eret       = MEM_WB_bus_r[BUS_ERET];
  assign pc         = MEM_WB_bus_r[BUS_PC_LSB +: 32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (WB_valid) begin
      if (hi_write) hi_q <= mem_result;
      if (lo_write) lo_q <= lo_result;
    end
  end

  cp0_regs #(
    .STATUS_WMASK(STATUS_WMASK)
  ) u_cp0 (
    .clk    (clk),
    .resetn (resetn),
    .wen    (WB_valid & mtc0),
    .addr   (cp0_addr),
    .wdata  (mem_result),
    .syscall(WB_valid & syscall),
    .eret   (WB_valid & eret),
    .pc     (pc),
    .rdata  (cp0_rdata),
    .status (cp0r_status),
    .cause  (cp0r_cause),
    .epc    (cp0r_epc)
  );

  always_comb begin
    rf_wdata = mem_result;
    if (mfhi)      rf_wdata = hi_q;
    else if (mflo) rf_wdata = lo_q;
    else if (mfc0) rf_wdata = cp0_rdata;
  end

  // eret returns to the EPC as it stands before this edge
  assign exc_valid = WB_valid & (syscall | eret);
  assign exc_pc    = syscall ? EXC_ENTER_ADDR : cp0r_epc;

  assign rf_wen      = WB_valid & bus_rf_wen & ~syscall & ~eret;
  assign WB_over     = WB_valid;
  assign WB_wdest    = rf_wdest & {5{WB_valid}};
  assign WB_RegWrite = rf_wen;
  assign WB_data     = rf_wdata;
  assign exc_bus     = {exc_valid, exc_pc};
  assign cancel      = exc_valid;
  assign WB_pc       = pc;
  assign HI_data     = hi_q;
  assign LO_data     = lo_q;

endmodule

// File: doc/wb.md
Name: wb

Overview:
- Final (write-back) stage of the pipeline; consumes the 118-bit MEM->WB bus produced by the memory-access stage.
- Owns the architectural HI/LO registers and the minimal CP0 set (STATUS, CAUSE, EPC).
- Drives the register-file write port and the WB bypass signals back to the memory stage.
- Raises the syscall/eret redirect and flush to the fetch side.

Parameters:
- EXC_ENTER_ADDR, 32'h0000_0000, PC target on syscall.
- STATUS_WMASK, 32'h0000_FF03, writable bits of STATUS: IM[15:8], EXL[1], IE[0].

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- WB_valid  in  1  stage holds a valid instruction
- MEM_WB_bus_r  in  118  registered bus, MSB->LSB: rf_wen, rf_wdest[4:0], mem_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, pc[31:0]
- rf_wen  out  1  register-file write enable
- rf_wdest  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- WB_over  out  1  stage finished this cycle
- WB_wdest  out  5  destination for hazard detection; 0 when invalid
- WB_RegWrite  out  1  bypass: a write is in flight (equals rf_wen)
- WB_data  out  32  bypass data (equals rf_wdata)
- exc_bus  out  33  {exc_valid, exc_pc}, redirect to fetch
- cancel  out  1  flush all younger stages
- WB_pc  out  32  PC of the stage, for display
- HI_data, LO_data  out  32 each  current HI/LO, for display
- cp0r_status, cp0r_cause, cp0r_epc  out  32 each  current CP0, for display

Behaviour:
- Reset (resetn low, asynchronous): HI=LO=0, STATUS=CAUSE=EPC=0. All combinational outputs then follow from these zero values and the inputs.
- Latency: every instruction completes in one cycle; WB_over = WB_valid. No stall source exists in this stage.
- State updates happen only on a clk rising edge with WB_valid=1. When WB_valid=0, nothing changes, rf_wen=0, exc_valid=0, cancel=0.
- rf_wen = WB_valid & rf_wen_bus & ~syscall & ~eret. A write to r0 is still issued; the register file ignores it.
- rf_wdata priority: mfhi -> HI; else mflo -> LO; else mfc0 -> CP0 read; else mem_result.
- Reads return the pre-edge value; there is no internal forwarding within the stage.
- HI/LO: hi_write -> HI<=mem_result; lo_write -> LO<=lo_result. Both may be set in the same cycle (mult/div).
- CP0 address = {rd[4:0], sel[2:0]}: STATUS = {12,0}, CAUSE = {13,0}, EPC = {14,0}. Any other address reads 0 and ignores writes.
- mtc0 writes mem_result:
  - STATUS <= (STATUS & ~STATUS_WMASK) | (mem_result & STATUS_WMASK).
  - EPC <= mem_result.
  - CAUSE is read-only to software.
- syscall, on its edge:
  - EPC <= pc; CAUSE[6:2] <= 5'd8 (other CAUSE bits unchanged); STATUS[1] <= 1.
  - Same cycle, combinational: exc_valid=1, exc_pc=EXC_ENTER_ADDR.
- eret: STATUS[1] <= 0; exc_valid=1, exc_pc=EPC (pre-edge value).
- cancel = exc_valid, one cycle per syscall/eret, combinational.
- Decode guarantees syscall, eret, mtc0 and hi/lo writes are mutually exclusive. If several are set anyway, the precedence is: syscall > eret > mtc0. Lower-priority CP0 writes are dropped; HI/LO writes still occur.
- mtc0 EPC followed by eret in the next cycle: eret uses the new EPC.
- Back-to-back syscalls: the second overwrites EPC, and CAUSE keeps 8.
- Reset asserted mid-instruction: all registers clear immediately. The instruction is lost and no exc_valid is held.
- WB_wdest = rf_wdest & {5{WB_valid}}; WB_pc = pc.

Decomposition:
- Shared package holds:
  - the MEM_WB bus width (118) and field offsets;
  - the CP0 addresses (STATUS 8'h60, CAUSE 8'h68, EPC 8'h70);
  - EXCCODE_SYS = 5'd8, STATUS_EXL bit = 1;
  - the exc_bus width (33).
- One sub-module, cp0_regs:
  - inputs: clk, resetn, wen, addr, wdata, syscall, eret, pc;
  - outputs: rdata, status, cause, epc.
  - HI/LO stay in wb.

Test Plan:
- Reset, then mfhi/mflo/mfc0 12,0 with rf_wdest=5 -> rf_wen=1, rf_wdata=0 for each.
- hi_write+lo_write with mem_result=32'h1234, lo_result=32'h5678; next mfhi -> 32'h1234, next mflo -> 32'h5678.
- mtc0 12,0 with 32'hFFFF_FFFF, then mfc0 12,0 -> 32'h0000_FF03; mtc0 13,0 with 32'hFFFF -> CAUSE stays 0.
- syscall at pc=32'hBFC0_0100 -> same cycle exc_bus={1,32'h0}, cancel=1, rf_wen=0; after the edge EPC=32'hBFC0_0100, CAUSE=32'h20, STATUS[1]=1.
- mtc0 EPC=32'h0000_0400, then eret next cycle -> exc_bus={1,32'h400}, STATUS[1] cleared after the edge.
- WB_valid=0 with a bus carrying syscall and hi_write -> no state change, exc_valid=0, WB_wdest=0. Assert resetn low mid-stream -> all CP0/HI/LO read 0.
